// File: rtl/timer_pkg.sv
// Shared types and default sizes for the down_timer block.
package timer_pkg;

    localparam int TIMER_WIDTH      = 8;
    localparam int TIMER_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        DONE   = 2'b11
    } t_timer_state;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider for the timer: emits a combinational tick every prescale+1
// enabled clocks; pcnt wraps naturally if prescale drops below it mid-run.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = TIMER_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick = en && (pcnt == prescale);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            if (pcnt == prescale) pcnt <= '0;
            else                  pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable prescaled down-counter with one-shot / auto-reload modes and a
// registered one-cycle terminal-count pulse.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = TIMER_WIDTH,
    parameter int PRESCALE_W = TIMER_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  tc
);

    t_timer_state     state, state_n;
    logic [WIDTH-1:0] reload, reload_n, count_n;
    logic             tc_n;
    logic             clr;
    logic             en;
    logic             tick;

    // A stop or load in this cycle freezes/clears the prescaler instead.
    assign en = (state == RUN) && !stop && !load;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_presc (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .clr      (clr),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        tc_n     = 1'b0;
        clr      = 1'b0;
        if (load) begin
            reload_n = load_val;
            count_n  = load_val;
            state_n  = IDLE;
            clr      = 1'b1;
        end else if (stop && state == RUN) begin
            state_n = PAUSED;
        end else if (start && state != RUN) begin
            state_n = RUN;
            if (state == DONE) begin
                count_n = reload;
                clr     = 1'b1;
            end
        end else if (state == RUN && tick) begin
            if (count > WIDTH'(1)) begin
                count_n = count - 1'b1;
            end else begin
                tc_n = 1'b1;
                if (auto_reload) begin
                    count_n = reload;
                end else begin
                    count_n = '0;
                    state_n = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            reload <= reload_n;
            tc     <= tc_n;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [3:0] prescale;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       tc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    down_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    int ntc;
    int nbusy_low;
    int tc_at[3];
    int frozen_bad;

    initial begin
        rstn = 1'b0; load = 1'b0; load_val = '0; start = 1'b0;
        stop = 1'b0; auto_reload = 1'b0; prescale = '0;
        cyc(); cyc();
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tc", 32'(tc), 0);
        rstn = 1'b1;
        cyc();

        // Async reset mid-run at count=5
        do_load(8'd7);
        do_start();
        chk("t1_start", 32'(count), 7);
        cyc(); cyc();
        chk("t1_cnt5", 32'(count), 5);
        #2 rstn = 1'b0;
        #1;
        chk("t1_async_count", 32'(count), 0);
        chk("t1_async_busy", 32'(busy), 0);
        chk("t1_async_done", 32'(done), 0);
        chk("t1_async_tc", 32'(tc), 0);
        cyc();
        rstn = 1'b1;
        ntc = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (tc) ntc++;
        end
        chk("t1_no_tc_after", 32'(ntc), 0);
        chk("t1_count_after", 32'(count), 0);

        // One-shot, prescale 0
        prescale = 4'd0; auto_reload = 1'b0;
        do_load(8'd4);
        chk("t2_load_busy", 32'(busy), 0);
        do_start();
        chk("t2_c4", 32'(count), 4);
        chk("t2_busy", 32'(busy), 1);
        cyc(); chk("t2_c3", 32'(count), 3);
        cyc(); chk("t2_c2", 32'(count), 2);
        cyc(); chk("t2_c1", 32'(count), 1);
        chk("t2_c1_tc", 32'(tc), 0);
        cyc();
        chk("t2_tc", 32'(tc), 1);
        chk("t2_c0", 32'(count), 0);
        chk("t2_done", 32'(done), 1);
        chk("t2_busy_off", 32'(busy), 0);
        ntc = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (tc) ntc++;
        end
        chk("t2_no_more_tc", 32'(ntc), 0);
        chk("t2_hold0", 32'(count), 0);

        // Auto-reload, prescale 2: period 9
        prescale = 4'd2; auto_reload = 1'b1;
        do_load(8'd3);
        do_start();
        ntc = 0; nbusy_low = 0;
        tc_at[0] = -1; tc_at[1] = -1; tc_at[2] = -1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (i == 3) chk("t3_c2", 32'(count), 2);
            if (i == 6) chk("t3_c1", 32'(count), 1);
            if (!busy) nbusy_low++;
            if (tc) begin
                if (ntc < 3) tc_at[ntc] = i;
                ntc++;
                chk("t3_reload", 32'(count), 3);
            end
        end
        chk("t3_ntc", 32'(ntc), 3);
        chk("t3_tc0", 32'(tc_at[0]), 9);
        chk("t3_tc1", 32'(tc_at[1]), 18);
        chk("t3_tc2", 32'(tc_at[2]), 27);
        chk("t3_busy", 32'(nbusy_low), 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t3_stopped", 32'(busy), 0);

        // Pause / resume
        prescale = 4'd0; auto_reload = 1'b0;
        do_load(8'd6);
        do_start();
        chk("t4_c6", 32'(count), 6);
        cyc(); cyc();
        chk("t4_c4", 32'(count), 4);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t4_stop_nodec", 32'(count), 4);
        chk("t4_paused", 32'(busy), 0);
        frozen_bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (count !== 8'd4 || tc !== 1'b0) frozen_bad++;
        end
        chk("t4_frozen", 32'(frozen_bad), 0);
        do_start();
        chk("t4_resume", 32'(count), 4);
        cyc(); chk("t4_c3", 32'(count), 3);
        cyc(); chk("t4_c2", 32'(count), 2);
        cyc(); chk("t4_c1", 32'(count), 1);
        cyc();
        chk("t4_tc", 32'(tc), 1);
        chk("t4_done", 32'(done), 1);

        // Load on the expiry cycle
        do_load(8'd2);
        do_start();
        cyc();
        chk("t5_c1", 32'(count), 1);
        do_load(8'd9);
        chk("t5_load_tc", 32'(tc), 0);
        chk("t5_load_cnt", 32'(count), 9);
        chk("t5_load_busy", 32'(busy), 0);
        chk("t5_load_done", 32'(done), 0);
        cyc();
        chk("t5_after_tc", 32'(tc), 0);

        // Stop on a tick cycle with prescale 1
        prescale = 4'd1;
        do_load(8'd5);
        do_start();
        cyc();
        chk("t5_pre", 32'(count), 5);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t5_stop_nodec", 32'(count), 5);
        chk("t5_stop_tc", 32'(tc), 0);

        // reload=0 in auto-reload mode
        prescale = 4'd1; auto_reload = 1'b1;
        do_load(8'd0);
        do_start();
        cyc();
        chk("t6_wait", 32'(tc), 0);
        cyc();
        chk("t6_tc_a", 32'(tc), 1);
        chk("t6_cnt0", 32'(count), 0);
        chk("t6_busy", 32'(busy), 1);
        cyc();
        chk("t6_gap", 32'(tc), 0);
        cyc();
        chk("t6_tc_b", 32'(tc), 1);

        // Restart from DONE reloads the count
        prescale = 4'd0; auto_reload = 1'b0;
        do_load(8'd2);
        do_start();
        cyc();
        cyc();
        chk("t6_os_tc", 32'(tc), 1);
        chk("t6_os_done", 32'(done), 1);
        do_start();
        chk("t6_restart_cnt", 32'(count), 2);
        chk("t6_restart_busy", 32'(busy), 1);
        cyc();
        chk("t6_restart_c1", 32'(count), 1);
        cyc();
        chk("t6_restart_tc", 32'(tc), 1);
        chk("t6_restart_c0", 32'(count), 0);
        chk("t6_restart_done", 32'(done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable, prescaled down-counter timer with one-shot and auto-reload modes.
- It is the counting-down counterpart of the team's free-running up counter.
- A controller loads a terminal count, starts the timer and receives a one-cycle terminal-count pulse when the timer expires.
- It is used as the event/delay source next to the flip-flop and counter primitives in the embedded datapath.

Parameters:
- WIDTH, 8: width of the count and reload value.
- PRESCALE_W, 4: width of the prescaler compare value.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rstn  input  1  asynchronous active-low reset.
- load  input  1  capture load_val into the reload register and the count.
- load_val  input  WIDTH  terminal count value.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at each expiry.
- prescale  input  PRESCALE_W  a tick occurs every prescale+1 clocks while running.
- count  output  WIDTH  current count (registered).
- busy  output  1  high while in RUN.
- done  output  1  level, high while in DONE.
- tc  output  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, count=0, reload=0, pcnt=0, busy=0, done=0, tc=0.
- States: IDLE, RUN, PAUSED, DONE. busy=(state==RUN); done=(state==DONE); no combinational input-to-output paths.
- Command priority per cycle: load > stop > start.
- load, any state: reload<=load_val, count<=load_val, pcnt<=0, state<=IDLE, tc<=0.
- start:
  - IDLE or PAUSED -> RUN; count and pcnt are kept.
  - DONE -> RUN with count<=reload and pcnt<=0.
  - In RUN, start is ignored.
- stop:
  - RUN -> PAUSED; count and pcnt are frozen.
  - In any other state, stop is ignored.
- Prescaler: only in RUN.
  - Each clk, if pcnt==prescale, a tick occurs and pcnt<=0; otherwise pcnt<=pcnt+1.
  - With prescale=0, a tick occurs every clock.
  - If prescale is changed mid-run to below the current pcnt, the next tick occurs after pcnt wraps; this is legal and no error is flagged.
- On tick:
  - count>1: count<=count-1.
  - count<=1 (expiry): tc<=1 for exactly one cycle.
    - auto_reload=1: count<=reload, stay in RUN.
    - auto_reload=0: count<=0, state<=DONE.
- Period: the tc period equals max(reload,1)*(prescale+1) clocks.
  - In auto-reload mode, count never displays 0 unless reload=0.
- tc is 0 in every cycle without an expiry, including a cycle with a simultaneous load.
- load and an expiry tick in the same cycle: load wins, no tc, state IDLE.
- stop and a tick in the same cycle: stop wins, no decrement, no tc.
- Arithmetic: unsigned, no underflow ever (count<=1 handled before decrement), no wrap past 0.
- Reset mid-count clears everything immediately; no tc pulse is emitted on reset.

Decomposition:
- Shared package timer_pkg:
  - State enum type t_timer_state {IDLE, RUN, PAUSED, DONE}, encoded 2'b00..2'b11.
  - Default constants TIMER_WIDTH=8 and TIMER_PRESCALE_W=4.
- One natural sub-module: tick_prescaler.
  - Holds pcnt, with inputs clk, rstn, en (=state==RUN), clr and prescale.
  - Output tick is a combinational pulse, consumed only by the parent register update.
- All other logic lives in down_timer.

Test Plan:
1. Reset with rstn=0 mid-run at count=5 -> count=0, busy=0, done=0 and tc=0 immediately (asynchronously), with no tc pulse afterwards.
2. load_val=4, prescale=0, auto_reload=0, start -> count 4,3,2,1 on successive clocks, then tc=1 for one cycle with count=0 and done=1; count stays 0 with no further tc.
3. load_val=3, prescale=2, auto_reload=1, start, run 30 clocks:
   - tc fires every 9 clocks (count sequence 3,2,1,3,…);
   - exactly 3 tc pulses occur, and busy stays 1 throughout.
4. load_val=6, prescale=0, start, stop after 2 ticks -> count holds 4 in PAUSED for 10 clocks; start -> resumes 3,2,1, then tc.
5. Simultaneous events:
   - load(load_val=9) on the expiry cycle -> no tc, count=9, state IDLE;
   - stop on a tick cycle -> no decrement.
6. load_val=0, auto_reload=1, prescale=1, start -> tc every 2 clocks and count stays 0. Then from DONE (one-shot, load_val=2), start -> count reloads to 2 and runs 2,1, then tc.
